// File: rtl/knight_rider_scanner.sv
// Knight Rider LED scanner: step prescaler, LEFT/RIGHT direction FSM, position counter and LED decoder.
// Optional fading trail behind the lit LED is enabled by defining KR_TRAIL_EN.
module knight_rider_scanner #(
    parameter  int N_LEDS    = 8,
    parameter  int PRESCALE  = 4,
    parameter  int TRAIL_LEN = 2,
    localparam int CNT_W     = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [CNT_W-1:0]  pos,
    output logic              dir,
    output logic              step,
    output logic [N_LEDS-1:0] leds
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(N_LEDS - 1);

    localparam logic [1:0] MODE_BOUNCE    = 2'b00;
    localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD      = 2'b11;

    if (N_LEDS < 2 || PRESCALE < 1 || TRAIL_LEN < 1) begin : g_bad_param
        $error("knight_rider_scanner: illegal parameter value");
    end

    typedef enum logic {
        ST_LEFT  = 1'b0,
        ST_RIGHT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [PS_W-1:0]  cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             tick_s;
    logic [N_LEDS-1:0] leds_s;

    assign tick_s = enable & (cnt_q == PS_MAX);

    // Next-state logic: prescaler always, scanner position/direction only on tick
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;

        if (tick_s) begin
            cnt_d = {PS_W{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + PS_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (tick_s) begin
            step_d = (mode != MODE_HOLD);
            case (mode)
                MODE_BOUNCE: begin
                    case (state_q)
                        ST_LEFT: begin
                            if (pos_q == POS_MAX) begin
                                state_d = ST_RIGHT;
                                pos_d   = POS_MAX - CNT_W'(1);
                            end else begin
                                pos_d = pos_q + CNT_W'(1);
                            end
                        end
                        ST_RIGHT: begin
                            if (pos_q == {CNT_W{1'b0}}) begin
                                state_d = ST_LEFT;
                                pos_d   = CNT_W'(1);
                            end else begin
                                pos_d = pos_q - CNT_W'(1);
                            end
                        end
                        default: begin
                            state_d = ST_LEFT;
                            pos_d   = {CNT_W{1'b0}};
                        end
                    endcase
                end
                MODE_WRAP_UP: begin
                    state_d = ST_LEFT;
                    pos_d   = (pos_q == POS_MAX) ? {CNT_W{1'b0}} : pos_q + CNT_W'(1);
                end
                MODE_WRAP_DOWN: begin
                    state_d = ST_RIGHT;
                    pos_d   = (pos_q == {CNT_W{1'b0}}) ? POS_MAX : pos_q - CNT_W'(1);
                end
                MODE_HOLD: begin
                    state_d = state_q;
                    pos_d   = pos_q;
                end
                default: begin
                    state_d = state_q;
                    pos_d   = pos_q;
                end
            endcase
        end else begin
            state_d = state_q;
            pos_d   = pos_q;
        end
    end

    // Scanner state, position, prescaler and step pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LEFT;
            pos_q   <= {CNT_W{1'b0}};
            cnt_q   <= {PS_W{1'b0}};
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

`ifdef KR_TRAIL_EN
    logic [CNT_W-1:0]     hist_pos_q [TRAIL_LEN];
    logic [TRAIL_LEN-1:0] hist_vld_q;

    // Trail history shifts in the outgoing position whenever a new one is presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TRAIL_LEN; i++) begin
                hist_pos_q[i] <= {CNT_W{1'b0}};
                hist_vld_q[i] <= 1'b0;
            end
        end else if (step_d) begin
            hist_pos_q[0] <= pos_q;
            hist_vld_q[0] <= 1'b1;
            for (int i = 1; i < TRAIL_LEN; i++) begin
                hist_pos_q[i] <= hist_pos_q[i-1];
                hist_vld_q[i] <= hist_vld_q[i-1];
            end
        end else begin
            for (int i = 0; i < TRAIL_LEN; i++) begin
                hist_pos_q[i] <= hist_pos_q[i];
                hist_vld_q[i] <= hist_vld_q[i];
            end
        end
    end

    // LED decode: head plus every valid trail entry
    always_comb begin
        leds_s = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_q;
        for (int i = 0; i < TRAIL_LEN; i++) begin
            if (hist_vld_q[i]) begin
                leds_s = leds_s | ({{(N_LEDS-1){1'b0}}, 1'b1} << hist_pos_q[i]);
            end else begin
                leds_s = leds_s;
            end
        end
    end
`else
    // LED decode: single lit position
    always_comb begin
        leds_s = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_q;
    end
`endif

    assign pos  = pos_q;
    assign dir  = state_q;
    assign step = step_q;
    assign leds = leds_s;

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Scoreboard bench for knight_rider_scanner (N_LEDS=8, PRESCALE=4): stimulus pushes hand-computed
// positions, a negedge monitor pops and compares on every step pulse.
module tb_knight_rider_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] pos;
    logic       dir;
    logic       step;
    logic [7:0] leds;

    knight_rider_scanner #(.N_LEDS(8), .PRESCALE(4), .TRAIL_LEN(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .mode    (mode),
        .pos     (pos),
        .dir     (dir),
        .step    (step),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pos;
        logic       dir;
        logic [7:0] leds;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Expected step sequence, each entry {dir, pos[2:0]}
    logic [3:0] vec [38] = '{
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd1, 4'd2,
        4'd3, 4'd4, 4'd5, 4'd6,
        4'd7, 4'd0, 4'd1,
        4'd8, 4'd15, 4'd14,
        4'd7, 4'd0, 4'd1, 4'd2, 4'd3,
        4'd4,
        4'd5, 4'd6, 4'd7, 4'd14, 4'd13,
        4'd12
    };
    int vi = 0;

    logic [2:0] cur_pos = 3'd0;
    logic [2:0] hb0 = 3'd0;
    logic [2:0] hb1 = 3'd0;
    logic [1:0] hv = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push(input logic [2:0] p, input logic d);
        exp_t e;
        logic [7:0] l;
        hb1 = hb0;
        hb0 = cur_pos;
        hv  = {hv[0], 1'b1};
        l = 8'd1 << p;
`ifdef KR_TRAIL_EN
        if (hv[0]) l = l | (8'd1 << hb0);
        if (hv[1]) l = l | (8'd1 << hb1);
`endif
        cur_pos = p;
        e.pos = p;
        e.dir = d;
        e.leds = l;
        exp_q.push_back(e);
    endtask

    task automatic push_n(input int n);
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            v = vec[vi];
            push(v[2:0], v[3]);
            vi++;
        end
    endtask

    task automatic wait_steps(input int n);
        int cyc;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (step !== 1'b1 && cyc < 40);
            if (step !== 1'b1) chk("step_timeout", 32'(step), 32'd1);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pos"}, 32'(pos), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_leds"}, 32'(leds), 32'h01);
    endtask

    // Monitor: every step pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && step === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_step: got step with pos %0d, expected no step", pos);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pos", 32'(pos), 32'(e.pos));
                chk("sb_dir", 32'(dir), 32'(e.dir));
                chk("sb_leds", 32'(leds), 32'(e.leds));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #2 reset_n = 1'b0;
        #1 chk_reset_state("reset_async");
        repeat (2) @(negedge clk);
        chk_reset_state("reset_held");
        enable  = 1'b1;
        mode    = 2'b00;
        reset_n = 1'b1;

        push_n(16);
        wait_steps(16);
        push_n(4);
        wait_steps(4);
        mode = 2'b01;
        push_n(3);
        wait_steps(3);
        mode = 2'b10;
        push_n(3);
        wait_steps(3);
        mode = 2'b01;
        push_n(5);
        wait_steps(5);

        // Freeze with the prescaler part-way through an interval
        mode = 2'b00;
        @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("frozen_step", 32'(step), 32'd0);
            chk("frozen_pos", 32'(pos), 32'd3);
        end
        enable = 1'b1;
        push_n(1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 chk("resume_early_step", 32'(step), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("resume_step", 32'(step), 32'd1);
        chk("resume_pos", 32'(pos), 32'd4);

        push_n(5);
        wait_steps(5);
        mode = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_step", 32'(step), 32'd0);
            chk("hold_pos", 32'(pos), 32'd5);
            chk("hold_dir", 32'(dir), 32'd1);
        end
        mode = 2'b00;
        push_n(1);
        wait_steps(1);
        @(negedge clk);
        #1 chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Mid-sweep reset, asserted away from any clock edge
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_reset_state("reset_mid");
        repeat (2) @(negedge clk);
        chk_reset_state("reset_mid_held");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
